exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL provide clk, input, 1, rising-edge system clock.
REQ-002 SHALL provide reset, input, 1, synchronous active-low reset: reset=0 at a rising clk edge resets the block.
REQ-003 SHALL provide issue_valid, input, 1, issue request from reservation station.
REQ-004 SHALL provide issue_is_LS, input, 1, op is load/store; compute address only.
REQ-005 SHALL provide issue_rd_tag, input, 6, destination physical register tag.
REQ-006 SHALL provide issue_rob_num, input, 6, ROB entry of the op.
REQ-007 SHALL provide issue_alusrc, input, 1, operand B select: 1 = imm, 0 = rs2_val.
REQ-008 SHALL provide issue_rs1_val, issue_rs2_val and issue_imm, each input, 32, operands.
REQ-009 SHALL provide issue_alu_type, input, 4, ALU opcode.
REQ-010 SHALL provide flush, input, 1, kill the in-flight op.
REQ-011 SHALL provide FU_ready, output, 1, unit accepts an issue this cycle.
REQ-012 SHALL provide wakeup_valid, output, 1, result broadcast qualifier.
REQ-013 SHALL provide wakeup_tag, output, 6, broadcast tag.
REQ-014 SHALL provide wakeup_val, output, 32, broadcast value.
REQ-015 SHALL provide complete_valid, output, 1, ROB completion pulse.
REQ-016 SHALL provide complete_rob_num, output, 6, completing ROB entry.
REQ-017 SHALL provide ls_valid, output, 1, address-ready pulse to load/store queue.
REQ-018 SHALL provide ls_addr, output, 32, effective address.
REQ-019 SHALL provide ls_data, output, 32, store data.
REQ-020 SHALL provide ls_rd_tag, output, 6, load destination tag.
REQ-021 SHALL provide ls_rob_num, output, 6, load/store ROB entry.

Function
REQ-022 SHALL accept an op at a rising edge where issue_valid=1, FU_ready=1, flush=0 and reset=1; otherwise issue inputs are ignored.
REQ-023 SHALL implement FSM states IDLE, MUL1, MUL2, with FU_ready=1 only in IDLE (combinational from state).
REQ-024 SHALL set operand B to issue_imm when issue_alusrc=1, else issue_rs2_val.
REQ-025 SHALL decode issue_alu_type: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low 32 bits); any other code yields result 0.
REQ-026 SHALL use B[4:0] as the shift amount; all arithmetic SHALL be modulo 2^32.
REQ-027 SHALL complete a non-MUL ALU op in 1 cycle: wakeup_valid=1 and complete_valid=1 for exactly the one cycle after the accept edge, with tag/rob/value registered from that op; FSM stays IDLE, allowing one accept per cycle.
REQ-028 SHALL handle MUL as a 3-cycle op: accept edge E0 IDLE->MUL1, E1 MUL1->MUL2, E2 MUL2->IDLE, with the result pulse in the cycle after E2; earliest next accept is E3.
REQ-029 SHALL suppress wakeup_valid when rd_tag=0; complete_valid SHALL still pulse.
REQ-030 SHALL handle issue_is_LS=1 in 1 cycle regardless of alu_type: ls_valid pulses in the cycle after accept with ls_addr=rs1_val+imm (wrapping), ls_data=rs2_val, ls_rd_tag and ls_rob_num; wakeup_valid=0 and complete_valid=0 for that op.
REQ-031 SHALL, on flush=1 at an edge, return the FSM to IDLE, discard any in-flight MUL, and drive all valid outputs 0 in the next cycle; an issue presented in the same cycle SHALL be dropped.
REQ-032 SHALL hold data outputs stable when the corresponding valid is 0; their values are don't-care to consumers.

Reset
REQ-033 SHALL, on reset=0 at an edge, enter IDLE and clear wakeup_valid, complete_valid, ls_valid, wakeup_tag, complete_rob_num, ls_rd_tag, ls_rob_num, wakeup_val, ls_addr and ls_data to 0; reset SHALL override issue and flush, including mid-MUL.
REQ-034 SHALL assert FU_ready=1 in the first cycle after reset is released.

Verification
REQ-035 SHALL cover: ADD rs1=1, rs2=2, alusrc=0, rd=10, rob=15 -> next cycle wakeup_valid=1, tag=10, val=3, complete_rob_num=15.
REQ-036 SHALL cover: back-to-back SUB 5-7 then SLTU 1<0xFFFFFFFF -> consecutive pulses with values 0xFFFFFFFE then 1.
REQ-037 SHALL cover: MUL 0x10000*0x10001, rd=30 -> FU_ready=0 for 2 cycles, pulse in the 3rd cycle with val=0x00010000; an issue held during busy is accepted at E3.
REQ-038 SHALL cover: LS op rs1=3, imm=0x100, rs2=0xAB, rd=20 -> ls_valid=1, ls_addr=0x103, ls_data=0xAB, wakeup_valid=0.
REQ-039 SHALL cover: flush at E1 of a MUL -> no pulse, FU_ready=1 next cycle; separately, reset=0 in MUL2 -> all outputs 0.
REQ-040 SHALL cover: ADD with rd=0 -> complete_valid=1, wakeup_valid=0.

Source files
------------

// File: rtl/exec_unit.sv
// Integer execute unit: single-cycle ALU and load/store address ops, three-cycle MUL.
// FU_ready is low while a MUL occupies the unit; flush discards the in-flight op.
module exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_LS,
    input  logic [5:0]  issue_rd_tag,
    input  logic [5:0]  issue_rob_num,
    input  logic        issue_alusrc,
    input  logic [31:0] issue_rs1_val,
    input  logic [31:0] issue_rs2_val,
    input  logic [31:0] issue_imm,
    input  logic [3:0]  issue_alu_type,
    input  logic        flush,
    output logic        FU_ready,
    output logic        wakeup_valid,
    output logic [5:0]  wakeup_tag,
    output logic [31:0] wakeup_val,
    output logic        complete_valid,
    output logic [5:0]  complete_rob_num,
    output logic        ls_valid,
    output logic [31:0] ls_addr,
    output logic [31:0] ls_data,
    output logic [5:0]  ls_rd_tag,
    output logic [5:0]  ls_rob_num
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_is_mul;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [5:0]  r_mul_tag;
    logic [5:0]  r_mul_rob;
    logic [31:0] r_mul_val;

    assign w_accept = issue_valid && FU_ready && !flush;
    assign w_is_mul = !issue_is_LS && (issue_alu_type == 4'b1010);
    assign w_b      = issue_alusrc ? issue_imm : issue_rs2_val;

    always_comb begin
        w_alu = 32'd0;
        case (issue_alu_type)
            4'b0000: w_alu = issue_rs1_val & w_b;
            4'b0001: w_alu = issue_rs1_val | w_b;
            4'b0010: w_alu = issue_rs1_val + w_b;
            4'b0110: w_alu = issue_rs1_val - w_b;
            4'b0011: w_alu = issue_rs1_val ^ w_b;
            4'b0100: w_alu = issue_rs1_val << w_b[4:0];
            4'b0101: w_alu = issue_rs1_val >> w_b[4:0];
            4'b0111: w_alu = $unsigned($signed(issue_rs1_val) >>> w_b[4:0]);
            4'b1000: w_alu = {31'd0, $signed(issue_rs1_val) < $signed(w_b)};
            4'b1001: w_alu = {31'd0, issue_rs1_val < w_b};
            4'b1010: w_alu = issue_rs1_val * w_b;
            default: w_alu = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept && w_is_mul) w_state_nxt = MUL1;
                MUL1:    w_state_nxt = MUL2;
                MUL2:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        FU_ready = (r_state == IDLE);
    end

    // Data outputs only move when their valid fires, so consumers see stable values otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wakeup_valid     <= 1'b0;
            wakeup_tag       <= 6'd0;
            wakeup_val       <= 32'd0;
            complete_valid   <= 1'b0;
            complete_rob_num <= 6'd0;
            ls_valid         <= 1'b0;
            ls_addr          <= 32'd0;
            ls_data          <= 32'd0;
            ls_rd_tag        <= 6'd0;
            ls_rob_num       <= 6'd0;
            r_mul_tag        <= 6'd0;
            r_mul_rob        <= 6'd0;
            r_mul_val        <= 32'd0;
        end else begin
            wakeup_valid   <= 1'b0;
            complete_valid <= 1'b0;
            ls_valid       <= 1'b0;
            if (!flush) begin
                if (r_state == MUL2) begin
                    complete_valid   <= 1'b1;
                    complete_rob_num <= r_mul_rob;
                    if (r_mul_tag != 6'd0) begin
                        wakeup_valid <= 1'b1;
                        wakeup_tag   <= r_mul_tag;
                        wakeup_val   <= r_mul_val;
                    end
                end else if (w_accept) begin
                    if (issue_is_LS) begin
                        ls_valid   <= 1'b1;
                        ls_addr    <= issue_rs1_val + issue_imm;
                        ls_data    <= issue_rs2_val;
                        ls_rd_tag  <= issue_rd_tag;
                        ls_rob_num <= issue_rob_num;
                    end else if (w_is_mul) begin
                        r_mul_tag <= issue_rd_tag;
                        r_mul_rob <= issue_rob_num;
                        r_mul_val <= w_alu;
                    end else begin
                        complete_valid   <= 1'b1;
                        complete_rob_num <= issue_rob_num;
                        if (issue_rd_tag != 6'd0) begin
                            wakeup_valid <= 1'b1;
                            wakeup_tag   <= issue_rd_tag;
                            wakeup_val   <= w_alu;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios then random traffic, all checked against
// a cycle-level reference model of issue/MUL occupancy/flush/reset behaviour.
module tb_exec_unit;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_is_LS;
    logic [5:0]  issue_rd_tag;
    logic [5:0]  issue_rob_num;
    logic        issue_alusrc;
    logic [31:0] issue_rs1_val;
    logic [31:0] issue_rs2_val;
    logic [31:0] issue_imm;
    logic [3:0]  issue_alu_type;
    logic        flush;
    logic        FU_ready;
    logic        wakeup_valid;
    logic [5:0]  wakeup_tag;
    logic [31:0] wakeup_val;
    logic        complete_valid;
    logic [5:0]  complete_rob_num;
    logic        ls_valid;
    logic [31:0] ls_addr;
    logic [31:0] ls_data;
    logic [5:0]  ls_rd_tag;
    logic [5:0]  ls_rob_num;

    exec_unit dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_is_LS      (issue_is_LS),
        .issue_rd_tag     (issue_rd_tag),
        .issue_rob_num    (issue_rob_num),
        .issue_alusrc     (issue_alusrc),
        .issue_rs1_val    (issue_rs1_val),
        .issue_rs2_val    (issue_rs2_val),
        .issue_imm        (issue_imm),
        .issue_alu_type   (issue_alu_type),
        .flush            (flush),
        .FU_ready         (FU_ready),
        .wakeup_valid     (wakeup_valid),
        .wakeup_tag       (wakeup_tag),
        .wakeup_val       (wakeup_val),
        .complete_valid   (complete_valid),
        .complete_rob_num (complete_rob_num),
        .ls_valid         (ls_valid),
        .ls_addr          (ls_addr),
        .ls_data          (ls_data),
        .ls_rd_tag        (ls_rd_tag),
        .ls_rob_num       (ls_rob_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: remaining busy cycles of a MUL plus its pending result.
    int          busy_left;
    logic [5:0]  m_tag;
    logic [5:0]  m_rob;
    logic [31:0] m_val;
    logic        post_rst;
    logic        model_known;
    logic        e_wv, e_cv, e_lv;
    logic [5:0]  e_wtag, e_crob, e_ltag, e_lrob;
    logic [31:0] e_wval, e_laddr, e_ldata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        prod;
        logic signed [63:0] sx;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd3:  return a ^ b;
            4'd4:  return a << b[4:0];
            4'd5:  return a >> b[4:0];
            4'd7: begin
                sx = {{32{a[31]}}, a};
                sx = sx >>> b[4:0];
                return sx[31:0];
            end
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] b;
        e_wv = 1'b0;
        e_cv = 1'b0;
        e_lv = 1'b0;
        if (!reset) begin
            busy_left = 0;
            post_rst  = 1'b1;
            e_wtag = 6'd0; e_crob = 6'd0; e_ltag = 6'd0; e_lrob = 6'd0;
            e_wval = 32'd0; e_laddr = 32'd0; e_ldata = 32'd0;
        end else begin
            post_rst = 1'b0;
            if (flush) begin
                busy_left = 0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    e_cv   = 1'b1;
                    e_crob = m_rob;
                    if (m_tag != 6'd0) begin
                        e_wv = 1'b1; e_wtag = m_tag; e_wval = m_val;
                    end
                end
            end else if (issue_valid) begin
                b = issue_alusrc ? issue_imm : issue_rs2_val;
                if (issue_is_LS) begin
                    e_lv    = 1'b1;
                    e_laddr = issue_rs1_val + issue_imm;
                    e_ldata = issue_rs2_val;
                    e_ltag  = issue_rd_tag;
                    e_lrob  = issue_rob_num;
                end else if (issue_alu_type == 4'd10) begin
                    busy_left = 2;
                    m_tag = issue_rd_tag;
                    m_rob = issue_rob_num;
                    m_val = ref_alu(issue_alu_type, issue_rs1_val, b);
                end else begin
                    e_cv   = 1'b1;
                    e_crob = issue_rob_num;
                    if (issue_rd_tag != 6'd0) begin
                        e_wv   = 1'b1;
                        e_wtag = issue_rd_tag;
                        e_wval = ref_alu(issue_alu_type, issue_rs1_val, b);
                    end
                end
            end
        end
        model_known = 1'b1;
    endtask

    // One clock: ready is checked before the edge, outputs at the following falling edge.
    task automatic step();
        if (model_known) check_val("fu_ready", 32'(FU_ready), (busy_left == 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("wakeup_valid", 32'(wakeup_valid), 32'(e_wv));
        check_val("complete_valid", 32'(complete_valid), 32'(e_cv));
        check_val("ls_valid", 32'(ls_valid), 32'(e_lv));
        if (e_wv || post_rst) begin
            check_val("wakeup_tag", 32'(wakeup_tag), 32'(e_wtag));
            check_val("wakeup_val", wakeup_val, e_wval);
        end
        if (e_cv || post_rst) check_val("complete_rob", 32'(complete_rob_num), 32'(e_crob));
        if (e_lv || post_rst) begin
            check_val("ls_addr", ls_addr, e_laddr);
            check_val("ls_data", ls_data, e_ldata);
            check_val("ls_rd_tag", 32'(ls_rd_tag), 32'(e_ltag));
            check_val("ls_rob", 32'(ls_rob_num), 32'(e_lrob));
        end
    endtask

    task automatic set_op(input logic ls, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic src,
                          input logic [5:0] rd, input logic [5:0] rob);
        issue_valid    = 1'b1;
        issue_is_LS    = ls;
        issue_alu_type = op;
        issue_rs1_val  = a;
        issue_rs2_val  = b;
        issue_imm      = imm;
        issue_alusrc   = src;
        issue_rd_tag   = rd;
        issue_rob_num  = rob;
    endtask

    task automatic idle_in();
        issue_valid = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        model_known = 1'b0;
        busy_left   = 0;
        reset = 1'b0;
        flush = 1'b0;
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 6'd0);
        issue_valid = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b1;

        // ADD 1+2 -> tag 10, rob 15
        set_op(1'b0, 4'd2, 32'd1, 32'd2, 32'd0, 1'b0, 6'd10, 6'd15);
        step();
        check_val("add_val", wakeup_val, 32'd3);
        check_val("add_rob", 32'(complete_rob_num), 32'd15);

        // back-to-back SUB then SLTU
        set_op(1'b0, 4'd6, 32'd5, 32'd7, 32'd0, 1'b0, 6'd11, 6'd1);
        step();
        check_val("sub_val", wakeup_val, 32'hFFFF_FFFE);
        set_op(1'b0, 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 6'd12, 6'd2);
        step();
        check_val("sltu_val", wakeup_val, 32'd1);

        // MUL, with an ADD held during the busy window
        set_op(1'b0, 4'd10, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0, 6'd30, 6'd3);
        step();
        set_op(1'b0, 4'd2, 32'd20, 32'd0, 32'd22, 1'b1, 6'd31, 6'd4);
        check_val("mul_busy1", 32'(FU_ready), 32'd0);
        step();
        check_val("mul_busy2", 32'(FU_ready), 32'd0);
        step();
        check_val("mul_val", wakeup_val, 32'h0001_0000);
        check_val("mul_tag", 32'(wakeup_tag), 32'd30);
        step();
        check_val("held_add_val", wakeup_val, 32'd42);

        // load/store address op
        set_op(1'b1, 4'd6, 32'd3, 32'hAB, 32'h100, 1'b0, 6'd20, 6'd5);
        step();
        check_val("ls_addr_dir", ls_addr, 32'h103);

        // ADD to tag 0: completes without wakeup
        set_op(1'b0, 4'd2, 32'd4, 32'd4, 32'd0, 1'b0, 6'd0, 6'd6);
        step();

        // flush at E1 of a MUL
        set_op(1'b0, 4'd10, 32'd7, 32'd9, 32'd0, 1'b0, 6'd7, 6'd7);
        step();
        idle_in();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();

        // reset asserted while in MUL2
        set_op(1'b0, 4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 6'd8, 6'd8);
        step();
        idle_in();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_val("rst_wval", wakeup_val, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            flush = ($urandom_range(0, 15) == 0);
            issue_valid    = $urandom_range(0, 1) == 1;
            issue_is_LS    = $urandom_range(0, 4) == 0;
            issue_alu_type = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            issue_rs1_val  = $urandom;
            issue_rs2_val  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue_imm      = $urandom;
            issue_alusrc   = $urandom_range(0, 1) == 1;
            issue_rd_tag   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            issue_rob_num  = 6'($urandom_range(0, 63));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
